// File: rtl/pool2_pkg.sv
// Shared types and helpers for the layer-2 pooling stream buffer.
package pool2_pkg;

    localparam int CH     = 8;
    localparam int DW     = 8;
    localparam int WORD_W = CH * DW;

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } state_t;

    // Per-channel unsigned max; on a tie the first operand wins.
    function automatic logic [WORD_W-1:0] chan_max(input logic [WORD_W-1:0] a,
                                                   input logic [WORD_W-1:0] b);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            r[c*DW +: DW] = (b[c*DW +: DW] > a[c*DW +: DW]) ? b[c*DW +: DW] : a[c*DW +: DW];
        end
        return r;
    endfunction

endpackage

// File: rtl/pool2_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is accepted
// only when a pop frees the slot in the same cycle.
module pool2_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     global_rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok, pop_ok;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push & (~full | pop) & ~clear;
    assign pop_ok  = pop & ~empty & ~clear;

    // Pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
        else if (!push_ok && pop_ok) level_d = level_q - 1'b1;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/pool2_stream_buffer.sv
// Layer-2 output pooling: per-channel 1-D max-pool (window 2, stride 2),
// FIFO buffering and valid/ready delivery to layer 3 with frame marking.
// Optional build macro: POOL_DROP_CNT_EN adds a saturating drop_count output.
//
//  state  | meaning
//  S_EVEN | no pending sample; next sample starts a pair (or is a lone last)
//  S_ODD  | first sample of a pair held in pend_q; next sample completes it
module pool2_stream_buffer
    import pool2_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 12
) (
    input  logic                          clk,
    input  logic                          global_rst,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic [WORD_W-1:0]             in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W-1:0]             out_data,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              pooled_count,
    output logic                          ovf_flag,
`ifdef POOL_DROP_CNT_EN
    output logic [CNT_W-1:0]              drop_count,
`endif
    output logic                          frame_done
);
    state_t              state_q, state_d;
    logic [WORD_W-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]    pooled_count_q, pooled_count_d;
    logic                ovf_q, ovf_d;
    logic                frame_done_q, frame_done_d;
    logic                push, pop, dropped;
    logic [WORD_W-1:0]   push_word;
    logic                push_last;
    logic [WORD_W:0]     head;
    logic                fifo_full, fifo_empty;
`ifdef POOL_DROP_CNT_EN
    logic [CNT_W-1:0]    drop_count_q, drop_count_d;
`endif

    pool2_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .global_rst (global_rst),
        .clear      (clear),
        .push       (push),
        .pop        (pop),
        .wr_data    ({push_last, push_word}),
        .rd_data    (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    assign out_valid    = ~fifo_empty;
    assign out_data     = fifo_empty ? '0 : head[WORD_W-1:0];
    assign out_last     = ~fifo_empty & head[WORD_W];
    assign pop          = out_valid & out_ready;
    assign dropped      = push & fifo_full & ~pop;
    assign pooled_count = pooled_count_q;
    assign ovf_flag     = ovf_q;
    assign frame_done   = frame_done_q;
`ifdef POOL_DROP_CNT_EN
    assign drop_count   = drop_count_q;
`endif

    // Pairing FSM, push formation and status counters.
    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        push           = 1'b0;
        push_word      = '0;
        push_last      = 1'b0;
        case (state_q)
            S_EVEN: begin
                if (in_valid) begin
                    if (in_last) begin
                        push      = 1'b1;
                        push_word = in_data;
                        push_last = 1'b1;
                    end else begin
                        pend_d  = in_data;
                        state_d = S_ODD;
                    end
                end
            end
            S_ODD: begin
                if (in_valid) begin
                    push      = 1'b1;
                    push_word = chan_max(pend_q, in_data);
                    push_last = in_last;
                    state_d   = S_EVEN;
                end
            end
            default: state_d = S_EVEN;
        endcase

        pooled_count_d = pooled_count_q;
        if (push) pooled_count_d = push_last ? '0 : pooled_count_q + 1'b1;
        ovf_d        = ovf_q | dropped;
        frame_done_d = pop & head[WORD_W];
`ifdef POOL_DROP_CNT_EN
        drop_count_d = drop_count_q;
        if (dropped && (drop_count_q != '1)) drop_count_d = drop_count_q + 1'b1;
`endif

        if (clear) begin
            state_d        = S_EVEN;
            pend_d         = '0;
            pooled_count_d = '0;
            ovf_d          = 1'b0;
            frame_done_d   = 1'b0;
`ifdef POOL_DROP_CNT_EN
            drop_count_d   = '0;
`endif
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            state_q        <= S_EVEN;
            pend_q         <= '0;
            pooled_count_q <= '0;
            ovf_q          <= 1'b0;
            frame_done_q   <= 1'b0;
`ifdef POOL_DROP_CNT_EN
            drop_count_q   <= '0;
`endif
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            pooled_count_q <= pooled_count_d;
            ovf_q          <= ovf_d;
            frame_done_q   <= frame_done_d;
`ifdef POOL_DROP_CNT_EN
            drop_count_q   <= drop_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_pool2_stream_buffer.sv
// Bench for pool2_stream_buffer: directed scenarios plus random traffic,
// all checked against a frame/queue level reference model.
module tb_pool2_stream_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        global_rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_last;
    logic [4:0]  fifo_level;
    logic [11:0] pooled_count;
    logic        ovf_flag;
    logic        frame_done;
`ifdef POOL_DROP_CNT_EN
    logic [11:0] drop_count;
`endif

    int checks = 0;
    int failures = 0;

    pool2_stream_buffer dut (
        .clk          (clk),
        .global_rst   (global_rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .fifo_level   (fifo_level),
        .pooled_count (pooled_count),
        .ovf_flag     (ovf_flag),
`ifdef POOL_DROP_CNT_EN
        .drop_count   (drop_count),
`endif
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model state.
    typedef struct packed {
        logic        l;
        logic [63:0] d;
    } w_t;
    w_t          mq[$];
    logic [63:0] frame_buf[$];
    int          m_pc;
    bit          m_ovf;
    int          m_dc;
    bit          m_fd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        frame_buf.delete();
        m_pc  = 0;
        m_ovf = 0;
        m_dc  = 0;
        m_fd  = 0;
    endtask

    function automatic logic [63:0] pool_max();
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < 8; c++) begin
            int m;
            m = 0;
            foreach (frame_buf[i]) begin
                if (int'(frame_buf[i][c*8 +: 8]) > m) m = int'(frame_buf[i][c*8 +: 8]);
            end
            r[c*8 +: 8] = 8'(m);
        end
        return r;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, mq.size() > 0);
        chk("fifo_level", fifo_level, mq.size());
        if (mq.size() > 0) begin
            chk("out_data", out_data, mq[0].d);
            chk("out_last", out_last, mq[0].l);
        end
        chk("pooled_count", pooled_count, m_pc);
        chk("ovf_flag", ovf_flag, m_ovf);
        chk("frame_done", frame_done, m_fd);
`ifdef POOL_DROP_CNT_EN
        chk("drop_count", drop_count, m_dc);
`endif
    endtask

    // One clock: drive inputs, advance DUT and model, compare.
    task automatic cyc(input bit v, input logic [63:0] d, input bit l, input bit r, input bit clr);
        bit pop_m;
        w_t popped;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        clear     = clr;
        pop_m = (mq.size() > 0) && r;
        @(posedge clk);
        #1;
        if (clr) begin
            model_reset();
        end else begin
            popped = '0;
            if (pop_m) popped = mq.pop_front();
            m_fd = pop_m && popped.l;
            if (v) begin
                frame_buf.push_back(d);
                if (frame_buf.size() == 2 || l) begin
                    w_t w;
                    w.d = pool_max();
                    w.l = l;
                    frame_buf.delete();
                    if (mq.size() < DEPTH) mq.push_back(w);
                    else begin
                        m_ovf = 1;
                        if (m_dc < 4095) m_dc++;
                    end
                    m_pc = l ? 0 : (m_pc + 1) % 4096;
                end
            end
        end
        check_outputs();
    endtask

    function automatic logic [63:0] ch(input int c, input int val);
        logic [63:0] r;
        r = '0;
        r[c*8 +: 8] = 8'(val);
        return r;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_frame_done", frame_done, 0);
        global_rst = 1'b0;

        // 1: pairs with ready high
        cyc(1, ch(0, 5), 0, 1, 0);
        cyc(1, ch(0, 9), 0, 1, 0);
        chk("t1_w0", out_data[7:0], 9);
        cyc(1, ch(0, 200), 0, 1, 0);
        cyc(1, ch(0, 3), 1, 1, 0);
        chk("t1_w1_last", out_last, 1);
        cyc(0, 0, 0, 1, 0);
        chk("t1_frame_done", frame_done, 1);
        cyc(0, 0, 0, 1, 0);
        chk("t1_fd_pulse", frame_done, 0);

        // 2: odd-length frame
        cyc(0, 0, 0, 0, 1);
        cyc(1, ch(7, 10), 0, 0, 0);
        cyc(1, ch(7, 4), 0, 0, 0);
        cyc(1, ch(7, 77), 1, 0, 0);
        chk("t2_pc_zero", pooled_count, 0);
        chk("t2_head", out_data[63:56], 10);
        cyc(0, 0, 0, 1, 0);
        chk("t2_tail", out_data[63:56], 77);
        chk("t2_tail_last", out_last, 1);
        cyc(0, 0, 0, 1, 0);

        // 3: overflow with consumer stalled
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 80; i++) cyc(1, {$urandom, $urandom}, 0, 0, 0);
        chk("t3_level", fifo_level, 16);
        chk("t3_ovf", ovf_flag, 1);
`ifdef POOL_DROP_CNT_EN
        chk("t3_drop", drop_count, 24);
`endif
        for (int i = 0; i < 18; i++) cyc(0, 0, 0, 1, 0);

        // 4: push and pop together while full
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 32; i++) cyc(1, {$urandom, $urandom}, 0, 0, 0);
        cyc(1, {$urandom, $urandom}, 0, 0, 0);
        cyc(1, {$urandom, $urandom}, 0, 1, 0);
        chk("t4_level", fifo_level, 16);
        chk("t4_ovf", ovf_flag, 0);
        for (int i = 0; i < 17; i++) cyc(0, 0, 0, 1, 0);

        // 5: asynchronous reset mid-frame
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, {$urandom, $urandom}, 0, 0, 0);
        in_valid   = 1'b0;
        global_rst = 1'b1;
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_level", fifo_level, 0);
        model_reset();
        @(posedge clk);
        #1;
        global_rst = 1'b0;
        cyc(1, ch(1, 33), 0, 0, 0);
        cyc(1, ch(1, 44), 1, 0, 0);
        chk("t5_pair", out_data[15:8], 44);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // 6: ties and extremes
        cyc(0, 0, 0, 0, 1);
        cyc(1, ch(3, 255), 0, 0, 0);
        cyc(1, ch(3, 255), 0, 0, 0);
        cyc(1, ch(3, 0), 0, 0, 0);
        cyc(1, ch(3, 0), 1, 0, 0);
        chk("t6_255", out_data[31:24], 255);
        cyc(0, 0, 0, 1, 0);
        chk("t6_0", out_data[31:24], 0);
        chk("t6_last", out_last, 1);
        cyc(0, 0, 0, 1, 0);

        // Random traffic
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(9, 0) < 7,
                {$urandom, $urandom},
                $urandom_range(7, 0) == 0,
                $urandom_range(9, 0) < 4,
                $urandom_range(199, 0) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
